// File: rtl/icache_param.sv
// Parametrised set-associative read-only instruction cache with an uncached single-word bypass.
// Define ICACHE_INVAL_EN to add the index-invalidate port (inv_req / inv_index / inv_done).
module icache_param #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic                         uncache,
    input  logic [31:0]                  addr,
    output logic                         addr_ok,
    output logic                         data_ok,
    output logic [LINE_WORDS*32-1:0]     rdata,
    output logic [3:0]                   rnum,
    output logic                         rd_req,
    output logic                         rd_type,
    output logic [31:0]                  rd_addr,
    input  logic                         rd_rdy,
    input  logic                         ret_valid,
    input  logic [LINE_WORDS*32-1:0]     ret_data
`ifdef ICACHE_INVAL_EN
    ,
    input  logic                         inv_req,
    input  logic [$clog2(SETS)-1:0]      inv_index,
    output logic                         inv_done
`endif
);

    localparam int LINE_BITS = LINE_WORDS * 32;
    localparam int OFF_W     = $clog2(LINE_WORDS * 4);
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = 32 - IDX_W - OFF_W;
    localparam int WOFF_W    = OFF_W - 2;
    localparam int RR_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [3:0] LW4 = 4'(LINE_WORDS);

    // state  | meaning
    // IDLE   | ready for a fetch (or an invalidate)
    // LOOKUP | tag compare on the buffered request; a hit returns data and may accept the next
    // MISS   | line read request held on the bridge
    // REFILL | waiting for the line; fills the victim way and forwards the words
    // UREQ   | single-word uncached read request held on the bridge
    // URESP  | waiting for the uncached word
    // INV    | clears every way of one set
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_REFILL = 3'd3,
        S_UREQ   = 3'd4,
        S_URESP  = 3'd5
`ifdef ICACHE_INVAL_EN
        ,
        S_INV    = 3'd6
`endif
    } state_t;

    state_t state_q, state_d;

    logic [31:2]           addr_q, addr_d;
    logic [RR_W-1:0]       victim_q, victim_d, victim_sel;
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       valid_d [SETS];
    logic [RR_W-1:0]       rr_q [SETS];
    logic [RR_W-1:0]       rr_d [SETS];

    logic [TAG_W-1:0]      tag_mem  [WAYS][SETS];
    logic [LINE_BITS-1:0]  data_mem [WAYS][SETS];
    logic [TAG_W-1:0]      tag_rd_q  [WAYS];
    logic [LINE_BITS-1:0]  data_rd_q [WAYS];

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx, look_idx;
    logic [WOFF_W-1:0]     req_off;
    logic                  hit, accept, fill_we;
    logic [LINE_BITS-1:0]  hit_line;
    logic                  unused_bits;

`ifdef ICACHE_INVAL_EN
    logic [IDX_W-1:0]      inv_idx_q, inv_idx_d;
`endif

    assign req_tag     = addr_q[31 -: TAG_W];
    assign req_idx     = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_off     = addr_q[OFF_W-1:2];
    assign look_idx    = addr[OFF_W+IDX_W-1:OFF_W];
    assign unused_bits = ^addr[1:0];
    assign accept      = valid && addr_ok;
    assign fill_we     = (state_q == S_REFILL) && ret_valid;

    // Arrays are read every cycle at the incoming index; LOOKUP always follows an acceptance.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill_we && victim_q == RR_W'(w)) begin
                tag_mem[w][req_idx]  <= req_tag;
                data_mem[w][req_idx] <= ret_data;
            end
            tag_rd_q[w]  <= tag_mem[w][look_idx];
            data_rd_q[w] <= data_mem[w][look_idx];
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_rd_q[w] == req_tag) begin
                hit      = 1'b1;
                hit_line = data_rd_q[w];
            end
        end
    end

    always_comb begin
        victim_sel = rr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim_sel = RR_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef ICACHE_INVAL_EN
                if (inv_req) state_d = S_INV;
                else
`endif
                if (accept) state_d = uncache ? S_UREQ : S_LOOKUP;
            end
            S_LOOKUP: begin
                if (!hit)        state_d = S_MISS;
                else if (accept) state_d = uncache ? S_UREQ : S_LOOKUP;
                else             state_d = S_IDLE;
            end
            S_MISS:   if (rd_rdy)    state_d = S_REFILL;
            S_REFILL: if (ret_valid) state_d = S_IDLE;
            S_UREQ:   if (rd_rdy)    state_d = S_URESP;
            S_URESP:  if (ret_valid) state_d = S_IDLE;
`ifdef ICACHE_INVAL_EN
            S_INV:    state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        rnum    = '0;
        rd_req  = 1'b0;
        rd_type = 1'b0;
        rd_addr = '0;
`ifdef ICACHE_INVAL_EN
        inv_done = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                addr_ok = 1'b1;
`ifdef ICACHE_INVAL_EN
                if (inv_req) addr_ok = 1'b0;
`endif
            end
            S_LOOKUP: begin
                addr_ok = hit;
                data_ok = hit;
                if (hit) begin
                    rdata = hit_line >> {req_off, 5'b0};
                    rnum  = LW4 - 4'(req_off);
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_type = 1'b1;
                rd_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
            end
            S_REFILL: begin
                data_ok = ret_valid;
                if (ret_valid) begin
                    rdata = ret_data >> {req_off, 5'b0};
                    rnum  = LW4 - 4'(req_off);
                end
            end
            S_UREQ: begin
                rd_req  = 1'b1;
                rd_addr = {addr_q, 2'b00};
            end
            S_URESP: begin
                data_ok = ret_valid;
                if (ret_valid) begin
                    rdata = {{(LINE_BITS-32){1'b0}}, ret_data[31:0]};
                    rnum  = 4'd1;
                end
            end
`ifdef ICACHE_INVAL_EN
            S_INV: inv_done = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        addr_d   = accept ? addr[31:2] : addr_q;
        victim_d = (state_q == S_LOOKUP && !hit) ? victim_sel : victim_q;
        valid_d  = valid_q;
        rr_d     = rr_q;
        if (fill_we) begin
            valid_d[req_idx][victim_q] = 1'b1;
            rr_d[req_idx] = (rr_q[req_idx] == RR_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + RR_W'(1);
        end
`ifdef ICACHE_INVAL_EN
        inv_idx_d = (state_q == S_IDLE && inv_req) ? inv_index : inv_idx_q;
        if (state_q == S_INV) begin
            valid_d[inv_idx_q] = '0;
            rr_d[inv_idx_q]    = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        victim_q <= victim_d;
`ifdef ICACHE_INVAL_EN
        inv_idx_q <= inv_idx_d;
`endif
    end

endmodule
